// File: rtl/mailbox_fifo_device_if.sv
// rtl/mailbox_fifo_device_if.sv - request/response bus bundle for the mailbox FIFO device
interface mailbox_fifo_device_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic                    req_i;
  logic                    we_i;
  logic [3:0]              be_i;
  logic [AddressWidth-1:0] addr_i;
  logic [DataWidth-1:0]    wdata_i;
  logic                    rvalid_o;
  logic [DataWidth-1:0]    rdata_o;
  logic                    err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/mailbox_fifo_device.sv
// rtl/mailbox_fifo_device.sv - register-mapped mailbox FIFO; MAILBOX_OVERFLOW_COUNT_EN adds the OVFL counter at 0x10
module mailbox_fifo_device #(
  parameter int Depth        = 8,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mailbox_fifo_device_if.slave  bus,
  output logic                  irq_o
);
  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;

  // Word offsets, i.e. addr[9:2]
  localparam logic [7:0] OffData   = 8'h00;
  localparam logic [7:0] OffStatus = 8'h01;
  localparam logic [7:0] OffCtrl   = 8'h02;
  localparam logic [7:0] OffThresh = 8'h03;
`ifdef MAILBOX_OVERFLOW_COUNT_EN
  localparam logic [7:0] OffOvfl   = 8'h04;
`endif

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;
  logic                 irq_en_q, irq_en_d;
  logic [LvlW-1:0]      thresh_q, thresh_d;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 irq_q;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic [7:0]           offset;
  logic [DataWidth-1:0] status_word;
`ifdef MAILBOX_OVERFLOW_COUNT_EN
  logic [15:0]          ovfl_q, ovfl_d;
`endif

  // Address bits outside the 1 kB window and the byte lane bits are not decoded
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[AddressWidth-1:10], bus.addr_i[1:0]};

  assign offset      = bus.addr_i[9:2];
  assign full        = (level_q == LvlW'(Depth));
  assign empty       = (level_q == '0);
  assign status_word = DataWidth'({8'(level_q), 6'b0, full, empty});

  // Decode the request and compute next state plus the response word
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    rdata_d  = '0;
    err_d    = 1'b0;
    push     = 1'b0;
`ifdef MAILBOX_OVERFLOW_COUNT_EN
    ovfl_d   = ovfl_q;
`endif
    if (bus.req_i) begin
      case (offset)
        OffData: begin
          if (bus.we_i) begin
            if (bus.be_i == 4'hF && !full) begin
              push     = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              level_d  = level_q + 1'b1;
            end else begin
              err_d = 1'b1;
`ifdef MAILBOX_OVERFLOW_COUNT_EN
              if (full && ovfl_q != 16'hFFFF) begin
                ovfl_d = ovfl_q + 16'd1;
              end
`endif
            end
          end else if (!empty) begin
            // Head word is taken from storage before any later push can touch it
            rdata_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
            level_d  = level_q - 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OffStatus: begin
          if (!bus.we_i) begin
            rdata_d = status_word;
          end
        end
        OffCtrl: begin
          if (bus.we_i) begin
            if (bus.be_i[0]) begin
              irq_en_d = bus.wdata_i[0];
              if (bus.wdata_i[1]) begin
                // Flush: drop everything by catching the read pointer up
                rd_ptr_d = wr_ptr_q;
                level_d  = '0;
              end
            end
          end else begin
            rdata_d = DataWidth'(irq_en_q);
          end
        end
        OffThresh: begin
          if (bus.we_i) begin
            if (bus.be_i[0]) begin
              thresh_d = bus.wdata_i[LvlW-1:0];
            end
          end else begin
            rdata_d = DataWidth'(thresh_q);
          end
        end
`ifdef MAILBOX_OVERFLOW_COUNT_EN
        OffOvfl: begin
          if (bus.we_i) begin
            ovfl_d = '0;
          end else begin
            rdata_d = DataWidth'(ovfl_q);
          end
        end
`endif
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  // FIFO storage is deliberately left without reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wdata_i;
    end
  end

  // Control state, response pipeline and registered interrupt
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      rvalid_q <= bus.req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      irq_q    <= irq_en_q && (thresh_q != '0) && (level_q >= thresh_q);
    end
  end

`ifdef MAILBOX_OVERFLOW_COUNT_EN
  // Saturating count of DATA writes lost to a full FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovfl_q <= '0;
    end else begin
      ovfl_q <= ovfl_d;
    end
  end
`endif

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
  assign irq_o        = irq_q;
endmodule

// File: doc/mailbox_fifo_device.md
MAILBOX_FIFO_DEVICE -- requirements
Module: mailbox_fifo_device

Interface
- REQ-001: The module SHALL have parameter Depth, default 8, meaning FIFO entries (power of two, >= 2).
- REQ-002: The module SHALL have parameter DataWidth, default 32, meaning bus data width.
- REQ-003: The module SHALL have parameter AddressWidth, default 32, meaning bus address width.
- REQ-004: clk_i  input  1  single clock, all state on rising edge.
- REQ-005: rst_i  input  1  reset, asynchronous, active-high.
- REQ-006: req_i  input  1  device request; always accepted, no grant.
- REQ-007: we_i  input  1  1 = write, 0 = read.
- REQ-008: be_i  input  4  byte enables.
- REQ-009: addr_i  input  AddressWidth  byte address; only bits [9:2] are decoded (1 kB window).
- REQ-010: wdata_i  input  DataWidth  write data.
- REQ-011: rvalid_o  output  1  response valid.
- REQ-012: rdata_o  output  DataWidth  read data, qualified by rvalid_o.
- REQ-013: err_o  output  1  error response, qualified by rvalid_o.
- REQ-014: irq_o  output  1  level interrupt, registered.

Function
- REQ-015: Every cycle with req_i=1 SHALL produce exactly one response, with rvalid_o=1 on the next cycle; responses SHALL be back-to-back capable, one per cycle, and in order.
- REQ-016: Register map (offset): 0x00 DATA, 0x04 STATUS (RO), 0x08 CTRL, 0x0C THRESH; any other offset SHALL respond with err_o=1, rdata_o=0, and no state change.
- REQ-017: DATA write with be_i=4'hF and FIFO not full SHALL push wdata_i; if full or be_i!=4'hF, it SHALL drop the data and set err_o=1.
- REQ-018: DATA read with FIFO not empty SHALL pop the head entry and return it; if empty, it SHALL return rdata_o=0 and err_o=1 with no pointer change.
- REQ-019: STATUS SHALL read as: bit0 empty, bit1 full, bits[15:8] level (zero-extended); writes to it SHALL be ignored and give err_o=0.
- REQ-020: CTRL bit0 SHALL be irq_en (R/W); bit1 SHALL be flush (write-1, self-clearing, reads 0); writes SHALL apply only when be_i[0]=1.
- REQ-021: Flush SHALL empty the FIFO in the cycle the write is accepted; level reads 0 on the next request.
- REQ-022: THRESH SHALL hold $clog2(Depth)+1 bits, R/W, written only when be_i[0]=1, with upper wdata bits ignored.
- REQ-023: Pointers SHALL be $clog2(Depth) bits and wrap from Depth-1 to 0; level SHALL be $clog2(Depth)+1 bits, range 0..Depth.
- REQ-024: irq_o SHALL be a registered copy of (irq_en && THRESH!=0 && level>=THRESH), so it asserts one cycle after the causing request is accepted; THRESH>Depth SHALL never fire.
- REQ-025: Read-data for DATA SHALL be the entry present at request time; a pop followed by a push in the next cycle SHALL NOT corrupt the returned word.

Reset
- REQ-026: While rst_i=1, rvalid_o, rdata_o, err_o, and irq_o SHALL be 0, pointers and level SHALL be 0, irq_en SHALL be 0, and THRESH SHALL be 0.
- REQ-027: Reset asserted with a response pending SHALL drop that response; no rvalid_o SHALL appear after reset releases for pre-reset requests.
- REQ-028: FIFO storage contents need not be reset.

Configuration
- REQ-029: With macro MAILBOX_OVERFLOW_COUNT_EN defined, offset 0x10 SHALL be OVFL, a 16-bit saturating count of dropped DATA writes caused by full; any write to it SHALL clear it, and it resets to 0.
- REQ-030: Without MAILBOX_OVERFLOW_COUNT_EN, offset 0x10 SHALL behave as unmapped (err_o=1), and no counter logic SHALL be present.

Verification
- REQ-031: Reset, then read STATUS -> rdata_o=0x00000001, err_o=0, and irq_o=0.
- REQ-032: Push 0x11..0x18 (Depth=8), then push 0x99 -> 9th response err_o=1, STATUS=0x00000802, and OVFL=1 when the macro is defined.
- REQ-033: Pop 8 times, then pop once more -> 0x11..0x18 returned in order, then rdata_o=0 with err_o=1, and STATUS=0x00000001.
- REQ-034: THRESH=3, CTRL=1, push 3 words -> irq_o rises the cycle after the 3rd write response; one pop -> irq_o falls one cycle after that response.
- REQ-035: Push 5 words, write CTRL=0x3 -> STATUS=0x00000001 and irq_en=1; then push 0xAB and pop -> 0xAB returned (pointers wrapped correctly).
- REQ-036: Back-to-back requests with rst_i pulsed mid-stream -> no rvalid_o for the request in flight, and STATUS=0x00000001 after release.
